// File: rtl/sseg_scan_mux_n.sv
// sseg_scan_mux_n: N-digit common-anode seven-segment scanner.
// Double-buffered digit data (commits only at frame boundaries), per-digit
// blanking, leading-zero suppression and PWM brightness gating.
module sseg_scan_mux_n #(
   parameter int DIGITS      = 4,
   parameter int SCAN_BITS   = 17,
   parameter int BRIGHT_BITS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4*DIGITS-1:0]      hex_in,
   input  logic [DIGITS-1:0]        dp_in,
   input  logic [DIGITS-1:0]        blank_in,
   input  logic                     lz_en,
   input  logic [BRIGHT_BITS-1:0]   bright,
   input  logic                     load,
   output logic                     frame_start,
   output logic [DIGITS-1:0]        an,
   output logic [7:0]               seg
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   // Active-low {g..a} pattern for one hex nibble.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      hex_to_seg = 7'h7F;
      case (v)
         4'h0: hex_to_seg = 7'b1000000;
         4'h1: hex_to_seg = 7'b1111001;
         4'h2: hex_to_seg = 7'b0100100;
         4'h3: hex_to_seg = 7'b0110000;
         4'h4: hex_to_seg = 7'b0011001;
         4'h5: hex_to_seg = 7'b0010010;
         4'h6: hex_to_seg = 7'b0000010;
         4'h7: hex_to_seg = 7'b1111000;
         4'h8: hex_to_seg = 7'b0000000;
         4'h9: hex_to_seg = 7'b0010000;
         4'hA: hex_to_seg = 7'b0001000;
         4'hB: hex_to_seg = 7'b0000011;
         4'hC: hex_to_seg = 7'b1000110;
         4'hD: hex_to_seg = 7'b0100001;
         4'hE: hex_to_seg = 7'b0000110;
         4'hF: hex_to_seg = 7'b0001110;
         default: hex_to_seg = 7'h7F;
      endcase
   endfunction

   logic [SCAN_BITS-1:0]   presc_reg;
   logic [IDX_W-1:0]       idx_reg;
   logic [4*DIGITS-1:0]    pend_hex_reg, act_hex_reg;
   logic [DIGITS-1:0]      pend_dp_reg, act_dp_reg;
   logic [DIGITS-1:0]      pend_blank_reg, act_blank_reg;
   logic                   pend_lz_reg, act_lz_reg;
   logic                   pend_valid_reg;
   logic                   frame_start_reg;
   logic [DIGITS-1:0]      an_reg;
   logic [7:0]             seg_reg;

   logic                   presc_wrap;
   logic                   wrap_to_zero;
   logic                   commit;
   logic                   lit;
   logic                   chain;
   logic [DIGITS-1:0]      digit_zero;
   logic [DIGITS-1:0]      digit_sup;
   logic [7:0]             digit_seg [DIGITS];
   logic [DIGITS-1:0]      an_next;
   logic [7:0]             seg_next;

   assign presc_wrap   = (presc_reg == '1);
   assign wrap_to_zero = presc_wrap && (idx_reg == IDX_LAST);
   assign commit       = wrap_to_zero && pend_valid_reg;

   // Per-digit pattern from the active buffer; a blanked digit is fully dark
   // and behaves as a zero for the suppression chain.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_zero[gi] = (act_hex_reg[4*gi +: 4] == 4'h0) || act_blank_reg[gi];
      assign digit_seg[gi]  = act_blank_reg[gi] ? 8'hFF :
                              {~act_dp_reg[gi],
                               digit_sup[gi] ? 7'h7F : hex_to_seg(act_hex_reg[4*gi +: 4])};
   end

   // Leading-zero chain: walk down from the top digit; digit 0 always shows.
   always_comb begin
      digit_sup = '0;
      chain     = act_lz_reg;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         chain        = chain && digit_zero[i];
         digit_sup[i] = chain;
      end
   end

   // PWM gate and next anode/segment values for the digit currently scanned.
   always_comb begin
      lit      = (bright == '1) || (presc_reg[SCAN_BITS-1 -: BRIGHT_BITS] < bright);
      an_next  = '1;
      seg_next = 8'hFF;
      if (lit) begin
         an_next  = ~(DIGITS'(1) << idx_reg);
         seg_next = digit_seg[idx_reg];
      end
   end

   // Prescaler, digit index and frame-start pulse.
   always_ff @(posedge clk) begin
      if (!rst) begin
         presc_reg       <= '0;
         idx_reg         <= '0;
         frame_start_reg <= 1'b0;
      end else begin
         presc_reg       <= presc_reg + 1'b1;
         frame_start_reg <= wrap_to_zero;
         if (presc_wrap)
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end
   end

   // Pending/active buffers: loads land in pending, which moves to active only
   // at the frame boundary so a frame is never drawn from mixed data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pend_hex_reg   <= '0;
         pend_dp_reg    <= '0;
         pend_blank_reg <= '0;
         pend_lz_reg    <= 1'b0;
         pend_valid_reg <= 1'b0;
         act_hex_reg    <= '0;
         act_dp_reg     <= '0;
         act_blank_reg  <= '0;
         act_lz_reg     <= 1'b0;
      end else begin
         if (commit) begin
            act_hex_reg   <= pend_hex_reg;
            act_dp_reg    <= pend_dp_reg;
            act_blank_reg <= pend_blank_reg;
            act_lz_reg    <= pend_lz_reg;
         end
         if (load) begin
            pend_hex_reg   <= hex_in;
            pend_dp_reg    <= dp_in;
            pend_blank_reg <= blank_in;
            pend_lz_reg    <= lz_en;
            pend_valid_reg <= 1'b1;
         end else if (commit) begin
            pend_valid_reg <= 1'b0;
         end
      end
   end

   // Registered pin drivers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         an_reg  <= '1;
         seg_reg <= 8'hFF;
      end else begin
         an_reg  <= an_next;
         seg_reg <= seg_next;
      end
   end

   assign frame_start = frame_start_reg;
   assign an          = an_reg;
   assign seg         = seg_reg;

endmodule

// File: tb/tb_sseg_scan_mux_n.sv
// tb_sseg_scan_mux_n: frame-level scoreboard for sseg_scan_mux_n
// (DIGITS=4, SCAN_BITS=4, BRIGHT_BITS=2 -> 16-cycle slots, 64-cycle frames).
module tb_sseg_scan_mux_n;

   localparam int DIGITS      = 4;
   localparam int SCAN_BITS   = 4;
   localparam int BRIGHT_BITS = 2;
   localparam int FRAME       = 64;
   localparam int SLOT        = 16;

   typedef struct {
      int          id;
      logic [31:0] segs;   // digit3..digit0 bytes
      int          on;     // lit cycles per digit slot
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [4*DIGITS-1:0]     hex_in;
   logic [DIGITS-1:0]       dp_in;
   logic [DIGITS-1:0]       blank_in;
   logic                    lz_en;
   logic [BRIGHT_BITS-1:0]  bright;
   logic                    load;
   logic                    frame_start;
   logic [DIGITS-1:0]       an;
   logic [7:0]              seg;

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          sfs    = 0;
   int          mfs    = 0;
   logic        rst_q  = 1'b1;
   bit          acc_on = 1'b0;
   int          acc_cnt = 0;
   int          bad = 0;
   logic [7:0]  act_seg [4];
   int          act_on  [4];

   sseg_scan_mux_n #(
      .DIGITS(DIGITS), .SCAN_BITS(SCAN_BITS), .BRIGHT_BITS(BRIGHT_BITS)
   ) dut (
      .clk(clk), .rst(rst), .hex_in(hex_in), .dp_in(dp_in),
      .blank_in(blank_in), .lz_en(lz_en), .bright(bright), .load(load),
      .frame_start(frame_start), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   // Reset level as seen by the DUT at the last rising edge.
   always @(posedge clk) rst_q <= rst;

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      if (frame_start === 1'b1) sfs++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_fs();
      int  n = 0;
      bit  seen = 1'b0;
      while (!seen && n < 4 * FRAME) begin
         @(negedge clk);
         n++;
         if (frame_start === 1'b1) begin
            sfs++;
            seen = 1'b1;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL fs_timeout: no frame_start after %0d cycles, required within %0d", n, FRAME);
      end
   endtask

   task automatic load_vec(input logic [15:0] h, input logic [3:0] dp,
                           input logic [3:0] blk, input logic lz);
      hex_in   = h;
      dp_in    = dp;
      blank_in = blk;
      lz_en    = lz;
      load     = 1'b1;
      tick();
      load     = 1'b0;
   endtask

   task automatic push(input int id, input logic [31:0] s, input int on);
      exp_t e;
      e.id   = id;
      e.segs = s;
      e.on   = on;
      sb_q.push_back(e);
   endtask

   task automatic check_first_enable();
      int n = 0;
      do begin
         tick();
         n++;
      end while (an === 4'hF && n < 2);
      checks++;
      if (an === 4'hF) begin
         errors++;
         $display("FAIL first_enable: an=%h after %0d cycles, required a digit enabled", an, n);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   task automatic check_frame(input int id);
      exp_t e;
      while (sb_q.size() > 0 && sb_q[0].id < id) begin
         e = sb_q.pop_front();
         checks++;
         errors++;
         $display("FAIL sb_missed: expected frame %0d never seen, now at frame %0d", e.id, id);
      end
      if (sb_q.size() == 0 || sb_q[0].id != id) return;
      e = sb_q.pop_front();
      for (int d = 0; d < 4; d++) begin
         checks++;
         if (act_seg[d] !== e.segs[8*d +: 8]) begin
            errors++;
            $display("FAIL seg_d%0d frame %0d: got %h, required %h", d, id, act_seg[d], e.segs[8*d +: 8]);
         end
         checks++;
         if (act_on[d] != e.on) begin
            errors++;
            $display("FAIL on_d%0d frame %0d: got %0d lit cycles, required %0d", d, id, act_on[d], e.on);
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL scan_pattern frame %0d: %0d bad samples, required 0", id, bad);
      end
      $display("frame %0d: seg=%h_%h_%h_%h on=%0d/%0d/%0d/%0d", id,
               act_seg[3], act_seg[2], act_seg[1], act_seg[0],
               act_on[3], act_on[2], act_on[1], act_on[0]);
   endtask

   // Collects each 64-sample frame between frame_start pulses and scores it.
   always @(negedge clk) begin
      if (!rst_q) begin
         checks++;
         if (an !== 4'hF || seg !== 8'hFF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%h seg=%h fs=%b, required an=f seg=ff fs=0", an, seg, frame_start);
         end
         acc_on = 1'b0;
         mfs    = 0;
      end else begin
         if (acc_on) begin
            if (an === 4'hF) begin
               if (seg !== 8'hFF) bad++;
            end else begin
               int dsel = -1;
               for (int i = 0; i < 4; i++) begin
                  logic [3:0] m;
                  m = 4'b0001 << i;
                  if (an === ~m) dsel = i;
               end
               if (dsel < 0) bad++;
               else begin
                  if (dsel != acc_cnt / SLOT) bad++;
                  if (act_on[dsel] == 0) act_seg[dsel] = seg;
                  else if (seg !== act_seg[dsel]) bad++;
                  act_on[dsel]++;
               end
            end
            acc_cnt++;
         end
         if (frame_start === 1'b1) begin
            if (acc_on) begin
               checks++;
               if (acc_cnt != FRAME) begin
                  errors++;
                  $display("FAIL frame_period: %0d cycles between frame_start, required %0d", acc_cnt, FRAME);
               end else begin
                  check_frame(mfs);
               end
            end
            mfs++;
            acc_on  = 1'b1;
            acc_cnt = 0;
            bad     = 0;
            for (int i = 0; i < 4; i++) begin
               act_seg[i] = 8'hFF;
               act_on[i]  = 0;
            end
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;
      lz_en = 1'b0; bright = 2'b11; load = 1'b0;
      ticks(3);
      rst = 1'b1;
      check_first_enable();

      // Frame 1: power-on data "0000"; load 12AF with all dp lit for frame 2.
      wait_fs();
      push(1, 32'hC0C0C0C0, 16);
      load_vec(16'h12AF, 4'hF, 4'h0, 1'b0);
      push(2, 32'h7924080E, 16);

      // Frame 2: two mid-frame loads; last one (2222) wins at frame 3.
      wait_fs();
      ticks(19);
      load_vec(16'h1111, 4'h0, 4'h0, 1'b0);
      tick();
      load_vec(16'h2222, 4'h0, 4'h0, 1'b0);
      push(3, 32'hA4A4A4A4, 16);

      // Frame 3: 3333 pending, then 4444 on the commit edge -> 3333 then 4444.
      wait_fs();
      ticks(5);
      load_vec(16'h3333, 4'h0, 4'h0, 1'b0);
      ticks(57);
      load_vec(16'h4444, 4'h0, 4'h0, 1'b0);
      push(4, 32'hB0B0B0B0, 16);
      push(5, 32'h99999999, 16);

      // Frame 5: leading-zero suppression on 0050 with dp on digit 3.
      wait_fs();
      load_vec(16'h0050, 4'b1000, 4'h0, 1'b1);
      push(6, 32'h7FFF92C0, 16);

      // Frame 6: all zeros with suppression -> only digit 0 shows.
      wait_fs();
      load_vec(16'h0000, 4'h0, 4'h0, 1'b1);
      push(7, 32'hFFFFFFC0, 4);

      // Frame 7: quarter brightness.
      wait_fs();
      bright = 2'b01;

      // Frame 8: brightness 0 (dark); queue 1234 with digit 1 blanked.
      wait_fs();
      bright = 2'b00;
      push(8, 32'hFFFFFFFF, 0);
      load_vec(16'h1234, 4'h0, 4'b0010, 1'b0);
      push(9, 32'hF9A4FF99, 16);

      // Frame 9: full brightness again.
      wait_fs();
      bright = 2'b11;

      // Frame 10: load 5555 then reset mid-frame; pending must be discarded.
      wait_fs();
      load_vec(16'h5555, 4'h0, 4'h0, 1'b0);
      ticks(20);
      rst = 1'b0;
      sfs = 0;
      ticks(2);
      rst = 1'b1;
      check_first_enable();
      push(1, 32'hC0C0C0C0, 16);
      push(2, 32'hC0C0C0C0, 16);
      wait_fs();
      wait_fs();
      wait_fs();
      ticks(2);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d expected frames unchecked, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop if the sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required to finish earlier");
      $fatal(1);
   end

endmodule

// File: doc/sseg_scan_mux_n.md
Name: sseg_scan_mux_n

Overview:
Parametrised successor to the 4-digit hex display multiplexer. Drives an N-digit common-anode seven-segment display from a packed hex word, and adds:
- tear-free double-buffered updates
- per-digit blanking
- leading-zero suppression
- PWM brightness control
Sits between data sources (keyboard scan-code path, score counters) and the board's an/seg pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
SCAN_BITS, 17, prescaler width; one digit slot = 2^SCAN_BITS clk cycles
BRIGHT_BITS, 4, brightness resolution; must be <= SCAN_BITS

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low
hex_in  input  4*DIGITS  digit values; nibble i drives digit i, digit 0 is rightmost
dp_in  input  DIGITS  decimal point per digit, 1 = lit
blank_in  input  DIGITS  per-digit blank, 1 = segments and dp dark
lz_en  input  1  leading-zero suppression enable
bright  input  BRIGHT_BITS  brightness level; all-ones = full on
load  input  1  one-cycle strobe; captures hex_in/dp_in/blank_in/lz_en into pending buffer
frame_start  output  1  one-cycle pulse when digit index wraps to 0
an  output  DIGITS  anode enables, active-low
seg  output  8  {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset (rst==0 at clk edge), all synchronous:
  - an = all ones, seg = 8'hFF, frame_start = 0
  - prescaler = 0, digit index = 0
  - pending and active buffers = 0, pending_valid = 0
- Prescaler:
  - Free-running SCAN_BITS counter, wraps at 2^SCAN_BITS-1.
  - At wrap, index increments; after DIGITS-1 it wraps to 0.
- frame_start: registered; high for exactly one cycle, the cycle after index transitions to 0.
- Double buffering:
  - load=1 copies inputs to pending and sets pending_valid.
  - At the index-wrap-to-0 edge with pending_valid=1, pending is copied to active and pending_valid clears.
  - load coincident with the commit edge: the new inputs go to pending and stay pending until the next frame; the previous pending content commits.
  - Multiple loads within a frame: last one wins.
  - bright is not buffered; it takes effect immediately.
- Leading-zero suppression (active.lz_en=1):
  - Scanning from digit DIGITS-1 downward, a digit with value 0 is suppressed while all more-significant digits are 0 or suppressed.
  - Digit 0 is never suppressed.
  - A suppressed digit has segments a-g dark; its dp still follows dp_in.
  - A blanked digit counts as zero for the suppression chain.
- Blank: blank=1 forces seg = 8'hFF for that digit while an stays driven. Brightness gating still applies.
- Brightness gate:
  - on = (bright == all ones) OR (prescaler[SCAN_BITS-1 -: BRIGHT_BITS] < bright).
  - bright = 0 gives an all ones permanently.
- Output stage:
  - an and seg are registered; one-cycle latency from index/prescaler state.
  - an = ~(one-hot(index)) when on, else all ones.
  - seg = 8'hFF whenever an is all ones.
- Segment encoding, active-low {g..a}:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - seg[7] = ~dp.
- Reset mid-frame: all state returns to reset values on the same edge; pending data is discarded.
- DIGITS=1: index stays 0; frame_start pulses at every prescaler wrap.

Test Plan:
Bench: DIGITS=4, SCAN_BITS=4, BRIGHT_BITS=2.
- Reset held 3 cycles, then released -> an=4'hF, seg=8'hFF during reset. After release, first digit enables within 2 cycles; frame_start every 64 cycles.
- load with hex_in=16'h12AF, bright=2'b11, lz_en=0 -> after next frame_start, scan shows:
  - an=1110: seg=0_0001110 (F)
  - an=1101: seg=0_0001000 (A)
  - an=1011: seg=0_0100100 (2)
  - an=0111: seg=0_1111001 (1)
  - each for 16 cycles
- Tear test: load 16'h1111, then load 16'h2222 two cycles later mid-frame -> current frame keeps old data; next frame shows all '2'. Load coincident with the commit edge is deferred one frame.
- lz_en=1, hex_in=16'h0050, dp_in=4'b1000 -> digit3 seg=0_1111111 (dp only), digit2 seg=1_1111111, digit1 '5', digit0 '0'. hex_in=0 -> only digit0 shows '0'.
- Brightness:
  - bright=2'b01 -> an active 4 of 16 cycles per slot
  - bright=2'b00 -> an stays all ones
  - bright=2'b11 -> active 16 of 16 cycles
- blank_in=4'b0010 -> digit1 seg=8'hFF with an1 low. Assert rst mid-frame -> outputs idle, pending_valid cleared (no commit at next frame).
